// File: rtl/load_store_unit.sv
// LDUR/STUR sequencer between the MEM stage and an edge-triggered data memory.
// Define LSU_FAULT_CHECK_EN to reject misaligned or out-of-range addresses.
module load_store_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              rspFault,
  output logic              busy,
  output logic [IDX_W-1:0]  memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memReadData
);

  localparam int unsigned IDX_LSB = 3;
  localparam int unsigned IDX_MSB = IDX_LSB + IDX_W - 1;

`ifdef LSU_FAULT_CHECK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    RESP   = 3'd3,
    FAULT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    RESP   = 3'd3
  } state_t;
`endif

  state_t              state, stateNext;
  logic                isWrite, isWriteNext;
  logic [IDX_W-1:0]    memAddrNext;
  logic [DATA_W-1:0]   memWriteDataNext;
  logic                memReadNext, memWriteNext;
  logic                rspValidNext;
  logic [DATA_W-1:0]   rspDataNext;

`ifdef LSU_FAULT_CHECK_EN
  logic addrFault;
  logic rspFaultNext;
  assign addrFault = (reqAddr[IDX_LSB-1:0] != '0) || (reqAddr[ADDR_W-1:IDX_MSB+1] != '0);
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{reqAddr[ADDR_W-1:IDX_MSB+1], reqAddr[IDX_LSB-1:0]};
  assign rspFault = 1'b0;
`endif

  assign reqReady = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);

  // State and all registered outputs; strobes come straight from flops so they never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      isWrite      <= 1'b0;
      memAddr      <= '0;
      memWriteData <= '0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      rspValid     <= 1'b0;
      rspData      <= '0;
`ifdef LSU_FAULT_CHECK_EN
      rspFault     <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      isWrite      <= isWriteNext;
      memAddr      <= memAddrNext;
      memWriteData <= memWriteDataNext;
      memRead      <= memReadNext;
      memWrite     <= memWriteNext;
      rspValid     <= rspValidNext;
      rspData      <= rspDataNext;
`ifdef LSU_FAULT_CHECK_EN
      rspFault     <= rspFaultNext;
`endif
    end
  end

  // Next state plus the values each output register takes at the coming edge.
  always_comb begin
    stateNext        = state;
    isWriteNext      = isWrite;
    memAddrNext      = memAddr;
    memWriteDataNext = memWriteData;
    memReadNext      = 1'b0;
    memWriteNext     = 1'b0;
    rspValidNext     = 1'b0;
    rspDataNext      = '0;
`ifdef LSU_FAULT_CHECK_EN
    rspFaultNext     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef LSU_FAULT_CHECK_EN
        if (reqValid && addrFault) begin
          stateNext    = FAULT;
          rspValidNext = 1'b1;
          rspFaultNext = 1'b1;
        end else
`endif
        if (reqValid) begin
          stateNext        = SETUP;
          isWriteNext      = reqWrite;
          memAddrNext      = reqAddr[IDX_MSB:IDX_LSB];
          memWriteDataNext = reqWData;
        end
      end
      SETUP: begin
        stateNext    = STROBE;
        memWriteNext = isWrite;
        memReadNext  = !isWrite;
      end
      STROBE: begin
        stateNext    = RESP;
        rspValidNext = 1'b1;
        rspDataNext  = isWrite ? DATA_W'(0) : memReadData;
      end
      RESP: stateNext = IDLE;
`ifdef LSU_FAULT_CHECK_EN
      FAULT: stateNext = IDLE;
`endif
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with an edge-triggered memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite;
  logic [63:0] reqAddr, reqWData;
  logic        rspValid, rspFault, busy;
  logic [63:0] rspData;
  logic [9:0]  memAddr;
  logic [63:0] memWriteData, memReadData;
  logic        memWrite, memRead;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspData(rspData), .rspFault(rspFault), .busy(busy),
    .memAddr(memAddr), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] benchMem [1024];
  logic [63:0] refMem   [1024];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lastHs = 0;
  bit          prevHold = 0;
  bit          lastFault = 0;
  logic        prevRead = 1'b0, prevWrite = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: acts only on rising strobe edges.
  always @(posedge memWrite) benchMem[memAddr] <= memWriteData;
  always @(posedge memRead)  memReadData <= benchMem[memAddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit faultOf(input logic [63:0] a);
`ifdef LSU_FAULT_CHECK_EN
    return (a % 8 != 0) || (a >= 64'd8192);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idxOf(input logic [63:0] a);
    return int'((a / 8) % 1024);
  endfunction

  // Response monitor and strobe protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (memRead || memWrite) begin
      chk("strobe_exclusive", 64'(memRead & memWrite), 64'd0);
      chk("strobe_no_repeat", 64'((memRead & prevRead) | (memWrite & prevWrite)), 64'd0);
    end
    prevRead  = memRead;
    prevWrite = memWrite;
    if (rspValid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=rspValid required=no_response (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("rsp_data", rspData, e.data);
        chk("rsp_fault", 64'(rspFault), 64'(e.fault));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) chk("reqReady_timeout", 64'(reqReady), 64'd1);
  endtask

  // Issue one request from a negedge; returns at a negedge. hold keeps reqValid high afterwards.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input bit hold);
    exp_t e;
    int   h, idx;
    bit   f;
    reqWrite = w; reqAddr = a; reqWData = d; reqValid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    h = cyc;
    f = faultOf(a);
    idx = idxOf(a);
    if (prevHold) chk("b2b_spacing", 64'(h - lastHs), lastFault ? 64'd2 : 64'd4);
    prevHold = hold; lastHs = h; lastFault = f;
    if (!hold) begin
      reqValid = 1'b0;
      reqAddr  = {$urandom, $urandom};
      reqWrite = 1'($urandom_range(0, 1));
    end
    if (f) begin
      e.data = 64'd0; e.fault = 1'b1; e.cyc = h;
    end else if (w) begin
      refMem[idx] = d;
      e.data = 64'd0; e.fault = 1'b0; e.cyc = h + 2;
    end else begin
      e.data = refMem[idx]; e.fault = 1'b0; e.cyc = h + 2;
    end
    q.push_back(e);
    @(negedge clk);
    chk("setup_ready_low", 64'(reqReady), 64'd0);
    chk("setup_no_strobe", 64'({memRead, memWrite}), 64'd0);
    if (!f) begin
      chk("setup_addr", 64'(memAddr), 64'(idx));
      chk("setup_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("strobe_addr", 64'(memAddr), 64'(idx));
      chk("strobe_write", 64'(memWrite), 64'(w));
      chk("strobe_read", 64'(memRead), 64'(!w));
      if (w) chk("strobe_wdata", memWriteData, d);
    end
  endtask

  task automatic checkReset();
    chk("rst_reqReady", 64'(reqReady), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({memRead, memWrite}), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    chk("rst_memWriteData", memWriteData, 64'd0);
    chk("rst_rspValid", 64'(rspValid), 64'd0);
    chk("rst_rspData", rspData, 64'd0);
    chk("rst_rspFault", 64'(rspFault), 64'd0);
  endtask

  // Issue an in-range request and reset it during SETUP (at=1) or STROBE (at=2).
  task automatic issueAbort(input logic w, input logic [63:0] a, input logic [63:0] d, input int at);
    reqWrite = w; reqAddr = a; reqWData = d; reqValid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (at) @(negedge clk);
    if (at == 2) begin
      chk("abort_strobe_write", 64'(memWrite), 64'(w));
      if (w) refMem[idxOf(a)] = d;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    prevHold = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      benchMem[i] = 64'h1000 + 64'(i) * 64'h0101_0101;
      refMem[i]   = 64'h1000 + 64'(i) * 64'h0101_0101;
    end
    benchMem[2] = 64'd8;
    refMem[2]   = 64'd8;
    memReadData = 64'd0;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 64'd0; reqWData = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(reqReady), 64'd1);

    issue(1'b0, 64'h10, 64'd0, 0);
    issue(1'b1, 64'h28, 64'hDEAD_BEEF, 0);
    issue(1'b0, 64'h28, 64'd0, 0);
    issue(1'b0, 64'h10, 64'd0, 1);
    issue(1'b0, 64'h18, 64'd0, 1);
    issue(1'b0, 64'h20, 64'd0, 0);
    @(negedge clk);
    issue(1'b0, 64'h13, 64'd0, 1);
    issue(1'b0, 64'h2000, 64'd0, 1);
    issue(1'b0, 64'h2008, 64'd0, 0);
    repeat (4) @(negedge clk);

    issueAbort(1'b1, 64'h38, 64'h55, 2);
    issue(1'b0, 64'h38, 64'd0, 0);
    issueAbort(1'b1, 64'h48, 64'h77, 1);
    issue(1'b0, 64'h48, 64'd0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [63:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, 15)) * 64'd8;
      else if (r == 7) a = {$urandom, $urandom};
      else             a = 64'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, bit'($urandom_range(0, 1)));
      if (!prevHold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    reqValid = 1'b0;
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the MEM pipeline stage and the data memory. It accepts one LDUR/STUR request per handshake and converts the 64-bit byte address into a 10-bit doubleword index. It drives the memory's edge-sensitive memRead/memWrite strobes with correct address/data setup, then returns load data or store completion to the pipeline as a single-cycle response.

## Interface
- ADDR_W, 64, request byte-address width
- IDX_W, 10, memory doubleword-index width (1024 entries)
- DATA_W, 64, data width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- reqValid  in  1  request present
- reqReady  out  1  block can accept; handshake when reqValid && reqReady at a clk edge
- reqWrite  in  1  1 = STUR, 0 = LDUR
- reqAddr  in  ADDR_W  byte address from ALU
- reqWData  in  DATA_W  store data
- rspValid  out  1  one-cycle completion pulse
- rspData  out  DATA_W  load data (0 for stores and faults)
- rspFault  out  1  request rejected; qualified by rspValid
- busy  out  1  state != IDLE
- memAddr  out  IDX_W  to data memory Addr
- memWriteData  out  DATA_W  to data memory writeData
- memWrite  out  1  store strobe; memory acts on its rising edge
- memRead  out  1  load strobe; memory acts on its rising edge
- memReadData  in  DATA_W  from data memory readData

## Operation
- States: IDLE, SETUP, STROBE, RESP, FAULT.
- IDLE: reqReady=1. On handshake:
  - Latch reqWrite, reqWData, and index = reqAddr[12:3].
  - Go to FAULT if the fault check fails; otherwise go to SETUP.
- SETUP: memAddr/memWriteData driven from latches; both strobes 0; go to STROBE.
- STROBE: raise exactly one strobe (memWrite if store, else memRead) for one cycle; memAddr/memWriteData held; go to RESP.
- RESP:
  - Both strobes 0; rspValid=1, rspFault=0.
  - rspData = memReadData registered at the STROBE->RESP edge for loads; 0 for stores.
  - Go to IDLE.
- FAULT: rspValid=1, rspFault=1, rspData=0; no strobe ever asserted; go to IDLE.
- memAddr and memWriteData stay stable from SETUP through RESP, and hold their last value in IDLE.
- Strobes are registered and glitch-free. Both are never high together, and each returns low between accesses so every access produces a fresh rising edge.
- reqReady=0 in every state except IDLE. No response backpressure: the consumer must take rspValid when it appears.

## Timing
- Handshake at edge E0.
- Cycle after E0: SETUP.
- Cycle after E1: STROBE (strobe high).
- Cycle after E2: RESP (rspValid high).
- Earliest next handshake at E4. Throughput is one access per 4 cycles.
- Fault path: rspValid is high in the cycle after E0; next handshake at E2.
- Reset (rst_n low at an edge), values after that edge:
  - State IDLE.
  - reqReady forced 0 while rst_n=0.
  - memRead=0, memWrite=0, memAddr=0, memWriteData=0.
  - rspValid=0, rspData=0, rspFault=0, busy=0.
- Reset mid-operation:
  - The response is dropped.
  - A store whose STROBE cycle already occurred stays committed in memory.
  - A store reset in SETUP is never written.
- reqValid while busy is ignored (not latched).

## Configuration
- LSU_FAULT_CHECK_EN defined:
  - Fault if reqAddr[2:0] != 0 (misaligned) or reqAddr[ADDR_W-1:13] != 0 (beyond 1024 doublewords).
  - Faulting requests take the FAULT path.
- LSU_FAULT_CHECK_EN undefined:
  - No checks; the FAULT state is not compiled.
  - Index is reqAddr[12:3] with upper and low bits silently dropped.
  - rspFault is tied 0.

## Test plan
- Load: bench memory index 2 = 64'd8; LDUR reqAddr=64'h10 -> memAddr=2 and memRead high exactly in cycle E0+2; rspValid in cycle E0+3 with rspData=64'd8, rspFault=0.
- Store then load:
  - STUR reqAddr=64'h28, reqWData=64'hDEAD_BEEF -> memWrite high one cycle, memAddr=5, rspData=0.
  - Following LDUR 64'h28 -> rspData=64'hDEAD_BEEF.
- Back-to-back: reqValid held high with 3 loads -> accepts at E0, E4, E8; reqReady low in between; strobe low for at least 1 cycle between accesses.
- Fault (macro on): LDUR 64'h13 -> rspValid+rspFault next cycle, rspData=0, no strobe. LDUR 64'h2000 -> same.
- Macro off: 64'h2008 -> access index 1, rspFault=0.
- Reset: assert rst_n=0 during STROBE of a store to index 7 with data 64'h55 -> next cycle strobes 0, busy 0, no rspValid; index 7 reads back 64'h55.
